// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC and IR, fetches over a req/ready memory handshake.
// Optional fetch timeout with sticky fault is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              pc_sel,
  input  logic              pc_write,
  input  logic              pc_rst,
  input  logic              br_sel,
  input  logic              ir_load,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       instr,
  output logic [3:0]        opcode,
  output logic [3:0]        mm,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_busy,
  output logic              fetch_fault
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_abs;
  logic [ADDR_W-1:0] br_rel;

  assign pc_inc = pc + ADDR_W'(1);
  assign br_abs = ADDR_W'(ir[15:0]);
  // Relative branches are taken from the already-incremented PC.
  assign br_rel = pc + ADDR_W'($signed(ir[15:0]));

  assign mem_addr = pc;
  assign pc_out   = pc;
  assign instr    = ir;
  assign opcode   = ir[31:28];
  assign mm       = ir[27:24];

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt;
`else
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state      <= ST_IDLE;
      pc         <= '0;
      ir         <= '0;
      mem_req    <= 1'b0;
      fetch_busy <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt     <= '0;
      fetch_fault <= 1'b0;
`endif
    end else if (pc_rst) begin
      // Clears PC in either state; an outstanding fetch is dropped and IR kept.
      state      <= ST_IDLE;
      pc         <= '0;
      mem_req    <= 1'b0;
      fetch_busy <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (mem_ready) begin
        ir         <= mem_rdata;
        pc         <= pc_inc;
        state      <= ST_IDLE;
        mem_req    <= 1'b0;
        fetch_busy <= 1'b0;
      end
`ifdef FETCH_TIMEOUT_EN
      else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
        ir          <= '0;
        pc          <= pc_inc;
        state       <= ST_IDLE;
        mem_req     <= 1'b0;
        fetch_busy  <= 1'b0;
        fetch_fault <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
`endif
    end else if (pc_write) begin
      if (pc_sel) begin
        if (!ir_load) begin
          pc <= br_sel ? br_abs : br_rel;
        end
      end else if (ir_load) begin
        state      <= ST_WAIT;
        mem_req    <= 1'b1;
        fetch_busy <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt    <= '0;
`endif
      end else begin
        pc <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table plus hand-written multi-cycle sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f, pc_sel, pc_write, pc_rst, br_sel, ir_load, mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_req, fetch_busy, fetch_fault;
  logic [15:0] mem_addr, pc_out;
  logic [31:0] instr;
  logic [3:0]  opcode, mm;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.ADDR_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_f(rst_f), .pc_sel(pc_sel), .pc_write(pc_write),
    .pc_rst(pc_rst), .br_sel(br_sel), .ir_load(ir_load),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_addr(mem_addr), .instr(instr), .opcode(opcode), .mm(mm),
    .pc_out(pc_out), .fetch_busy(fetch_busy), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_f, pc_sel, pc_write, pc_rst, br_sel, ir_load, mem_ready;
    logic [31:0] rdata;
    logic [15:0] e_pc;
    logic [31:0] e_ir;
    logic        e_req, e_busy;
  } vec_t;

  function automatic vec_t mk(input logic r, s, w, p, b, l, rd, input logic [31:0] dat,
                              input logic [15:0] epc, input logic [31:0] eir,
                              input logic ereq, ebusy);
    vec_t v;
    v.rst_f = r; v.pc_sel = s; v.pc_write = w; v.pc_rst = p; v.br_sel = b;
    v.ir_load = l; v.mem_ready = rd; v.rdata = dat;
    v.e_pc = epc; v.e_ir = eir; v.e_req = ereq; v.e_busy = ebusy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, s, w, p, b, l, rd, input logic [31:0] dat);
    rst_f = r; pc_sel = s; pc_write = w; pc_rst = p; br_sel = b;
    ir_load = l; mem_ready = rd; mem_rdata = dat;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] epc, input logic [31:0] eir,
                           input logic ereq, input logic ebusy);
    logic [31:0] e;
    e = eir;
    chk({tag, ".pc"}, 32'(pc_out), 32'(epc));
    chk({tag, ".addr"}, 32'(mem_addr), 32'(epc));
    chk({tag, ".ir"}, instr, eir);
    chk({tag, ".opcode"}, 32'(opcode), 32'(e[31:28]));
    chk({tag, ".mm"}, 32'(mm), 32'(e[27:24]));
    chk({tag, ".req"}, 32'(mem_req), 32'(ereq));
    chk({tag, ".busy"}, 32'(fetch_busy), 32'(ebusy));
  endtask

  // Idle cycle: only memory handshake inputs vary.
  task automatic idle(input logic rd, input logic [31:0] dat);
    drive(1, 0, 0, 0, 0, 0, rd, dat);
    tick;
  endtask

  task automatic start_fetch;
    drive(1, 0, 1, 0, 0, 1, 0, 32'h0);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  vec_t vecs[21];
  int   busy_cycles;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);

    //            rst sel wr prst bsel ld rdy rdata          pc       ir            req busy
    vecs[0]  = mk(0,  0,  1, 0,   0,   1, 0,  32'h0,         16'h0,   32'h0,        0,  0);
    vecs[1]  = mk(0,  0,  1, 0,   0,   1, 0,  32'h0,         16'h0,   32'h0,        0,  0);
    vecs[2]  = mk(1,  0,  1, 0,   0,   1, 0,  32'h0,         16'h0,   32'h0,        1,  1);
    vecs[3]  = mk(1,  0,  0, 0,   0,   0, 1,  32'h8100_0005, 16'h1,   32'h8100_0005,0,  0);
    vecs[4]  = mk(1,  0,  0, 0,   0,   0, 0,  32'h0,         16'h1,   32'h8100_0005,0,  0);
    vecs[5]  = mk(1,  0,  1, 0,   0,   1, 0,  32'h0,         16'h1,   32'h8100_0005,1,  1);
    vecs[6]  = mk(1,  0,  0, 0,   0,   0, 1,  32'hA000_000F, 16'h2,   32'hA000_000F,0,  0);
    vecs[7]  = mk(1,  1,  1, 0,   1,   0, 0,  32'h0,         16'hF,   32'hA000_000F,0,  0);
    vecs[8]  = mk(1,  0,  1, 0,   0,   1, 0,  32'h0,         16'hF,   32'hA000_000F,1,  1);
    vecs[9]  = mk(1,  0,  0, 0,   0,   0, 1,  32'h9000_FFFE, 16'h10,  32'h9000_FFFE,0,  0);
    vecs[10] = mk(1,  1,  1, 0,   0,   0, 0,  32'h0,         16'hE,   32'h9000_FFFE,0,  0);
    vecs[11] = mk(1,  0,  1, 0,   0,   1, 0,  32'h0,         16'hE,   32'h9000_FFFE,1,  1);
    vecs[12] = mk(1,  0,  0, 0,   0,   0, 1,  32'h0000_0040, 16'hF,   32'h0000_0040,0,  0);
    vecs[13] = mk(1,  1,  1, 0,   1,   0, 0,  32'h0,         16'h40,  32'h0000_0040,0,  0);
    vecs[14] = mk(1,  0,  1, 0,   0,   0, 0,  32'h0,         16'h41,  32'h0000_0040,0,  0);
    vecs[15] = mk(1,  1,  0, 0,   1,   0, 0,  32'h0,         16'h41,  32'h0000_0040,0,  0);
    vecs[16] = mk(1,  0,  0, 0,   0,   0, 1,  32'hDEAD_BEEF, 16'h41,  32'h0000_0040,0,  0);
    vecs[17] = mk(1,  0,  1, 0,   0,   1, 0,  32'h0,         16'h41,  32'h0000_0040,1,  1);
    vecs[18] = mk(1,  0,  0, 1,   0,   0, 1,  32'h1234_5678, 16'h0,   32'h0000_0040,0,  0);
    vecs[19] = mk(1,  0,  1, 0,   0,   0, 0,  32'h0,         16'h1,   32'h0000_0040,0,  0);
    vecs[20] = mk(1,  0,  1, 1,   0,   0, 0,  32'h0,         16'h0,   32'h0000_0040,0,  0);

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst_f, vecs[i].pc_sel, vecs[i].pc_write, vecs[i].pc_rst,
            vecs[i].br_sel, vecs[i].ir_load, vecs[i].mem_ready, vecs[i].rdata);
      tick;
      chk_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_req, vecs[i].e_busy);
      chk($sformatf("vec%0d.fault", i), 32'(fetch_fault), 32'h0);
    end

    // Three memory wait states: busy spans the issue cycle plus three waits.
    start_fetch;
    busy_cycles = fetch_busy ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      idle(0, 32'hBAD0_0000);
      if (fetch_busy) busy_cycles++;
      chk($sformatf("wait3.ir_hold%0d", k), instr, 32'h0000_0040);
    end
    idle(1, 32'h0000_FFFF);
    chk_state("wait3.done", 16'h1, 32'h0000_FFFF, 0, 0);
    chk("wait3.busy_cycles", 32'(busy_cycles), 32'd4);

    // PC wrap: branch to 0xFFFF, then a completed fetch rolls over to 0.
    drive(1, 1, 1, 0, 1, 0, 0, 32'h0);
    tick;
    chk("wrap.branch_pc", 32'(pc_out), 32'h0000_FFFF);
    start_fetch;
    chk("wrap.req_addr", 32'(mem_addr), 32'h0000_FFFF);
    idle(1, 32'h1234_5678);
    chk_state("wrap.done", 16'h0, 32'h1234_5678, 0, 0);

`ifdef FETCH_TIMEOUT_EN
    start_fetch;
    for (int k = 0; k < 14; k++) idle(0, 32'h0);
    chk("tmo.busy_before", 32'(fetch_busy), 32'h1);
    chk("tmo.fault_before", 32'(fetch_fault), 32'h0);
    idle(0, 32'h0);
    chk_state("tmo.expire", 16'h1, 32'h0, 0, 0);
    chk("tmo.fault_set", 32'(fetch_fault), 32'h1);
    start_fetch;
    idle(1, 32'h2222_0000);
    chk_state("tmo.next", 16'h2, 32'h2222_0000, 0, 0);
    chk("tmo.fault_sticky", 32'(fetch_fault), 32'h1);
`else
    start_fetch;
    for (int k = 0; k < 20; k++) idle(0, 32'h0);
    chk("nowait.busy_held", 32'(fetch_busy), 32'h1);
    chk("nowait.fault_low", 32'(fetch_fault), 32'h0);
    idle(1, 32'h2222_0000);
    chk_state("nowait.done", 16'h1, 32'h2222_0000, 0, 0);
`endif

    drive(0, 0, 1, 0, 0, 1, 1, 32'hFFFF_FFFF);
    tick;
    chk_state("final_rst", 16'h0, 32'h0, 0, 0);
    chk("final_rst.fault", 32'(fetch_fault), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the SISC control FSM; owns the program counter (PC) and the instruction register (IR).
- Drives opcode/mm into the controller and executes the controller's pc_sel/pc_write/pc_rst/br_sel/ir_load commands.
- Talks to instruction memory through a req/ready handshake, so memory may insert wait states.
- Raises fetch_busy so the controller can hold its state while a fetch is outstanding.

Parameters:
- ADDR_W, 16, PC and memory address width.
- TIMEOUT, 15, maximum wait cycles for mem_ready (used only with the optional feature).

Ports:
- clk  in  1  system clock, posedge active.
- rst_f  in  1  synchronous, active-low reset.
- pc_sel  in  1  0 = PC+1, 1 = branch target.
- pc_write  in  1  commit the selected value to PC.
- pc_rst  in  1  synchronous PC clear.
- br_sel  in  1  1 = absolute target, 0 = relative target.
- ir_load  in  1  start an instruction fetch.
- mem_rdata  in  32  instruction memory read data.
- mem_ready  in  1  memory data valid this cycle.
- mem_req  out  1  read request.
- mem_addr  out  ADDR_W  read address, equals PC.
- instr  out  32  IR contents.
- opcode  out  4  instr[31:28].
- mm  out  4  instr[27:24].
- pc_out  out  ADDR_W  current PC.
- fetch_busy  out  1  fetch outstanding; controller stalls.
- fetch_fault  out  1  timeout flag (optional feature).

Behaviour:
- Reset (rst_f low at posedge):
  - PC = 0, IR = 0, state = IDLE.
  - mem_req = 0, fetch_busy = 0, fetch_fault = 0.
  - All inputs are ignored during that cycle.
- States: IDLE, WAIT.
- IDLE:
  - ir_load=1 && pc_write=1 && pc_sel=0 → go to WAIT.
  - mem_req=1 and fetch_busy=1 are registered, so both assert the next cycle.
  - mem_addr = PC.
- WAIT:
  - mem_req stays high until mem_ready=1 is sampled.
  - On that edge: IR <= mem_rdata, PC <= PC+1 (mod 2^ADDR_W, so 0xFFFF wraps to 0x0000), state = IDLE.
  - mem_req and fetch_busy drop in the same cycle.
  - Minimum fetch latency is 2 cycles from ir_load to a valid IR; each memory wait cycle adds 1.
- Branch:
  - In IDLE with pc_write=1, pc_sel=1, ir_load=0, PC <= target at the posedge.
  - br_sel=1: target = instr[15:0] (absolute).
  - br_sel=0: target = PC + sign-extended instr[15:0] (relative). PC has already been incremented past the branch; the result is truncated to ADDR_W.
- pc_write=1 with pc_sel=0 and ir_load=0: PC <= PC+1 with no fetch.
- pc_write=0: PC holds.
- Priority: rst_f > pc_rst > WAIT completion > branch/increment.
- pc_rst=1 in IDLE: PC <= 0.
- pc_rst=1 in WAIT: the fetch is aborted, PC <= 0, IR unchanged, mem_req drops next cycle, state = IDLE.
- In WAIT, pc_write and ir_load are ignored; the controller must not issue them while fetch_busy=1.
- mem_ready in IDLE is ignored.
- opcode and mm are combinational slices of IR and are stable between fetches.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit+ counter runs in WAIT.
  - If TIMEOUT cycles elapse without mem_ready: IR <= 32'h0000_0000 (NOOP), PC <= PC+1, state = IDLE, fetch_fault = 1.
  - fetch_fault is sticky until rst_f.
  - The counter clears on each new fetch.
- Not defined:
  - No counter; WAIT persists indefinitely.
  - fetch_fault is tied to 0.

Test Plan:
- Reset: rst_f=0 for 2 cycles with ir_load=1 → PC=0, IR=0, mem_req=0; after release, ir_load+pc_write → mem_req=1 and mem_addr=0x0000 the next cycle.
- Zero-wait fetch: mem_ready=1 on the first WAIT cycle with mem_rdata=0x8100_0005 → IR=0x8100_0005, opcode=8, mm=1, PC=1, fetch_busy low after 2 cycles.
- 3-wait fetch: mem_ready delayed 3 cycles → fetch_busy high 4 cycles; IR loads only on the ready edge.
- Branches:
  - PC=0x0010, IR[15:0]=0xFFFE, br_sel=0, pc_sel=1, pc_write=1 → PC=0x000E.
  - br_sel=1 with IR[15:0]=0x0040 → PC=0x0040.
- Wrap and abort:
  - PC=0xFFFF fetch completes → PC=0x0000.
  - pc_rst during WAIT → PC=0, mem_req low next cycle, IR unchanged.
- FETCH_TIMEOUT_EN: mem_ready held 0 for 15 cycles → IR=0, PC+1, fetch_fault=1, held until rst_f.
